// File: rtl/reg_upd_handshake.sv
// Register update arbiter: software write vs. hardware update, handed over a toggle handshake.
// Optional checkers are enabled with REG_UPD_HANDSHAKE_ASSERT_EN.
module reg_upd_handshake #(
   parameter int unsigned          DataWidth  = 32,
   parameter logic [DataWidth-1:0] ResetVal   = '0,
   parameter bit                   HwUpd      = 1'b0,
   parameter int unsigned          SyncStages = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 sw_req_i,
   input  logic                 hw_update_i,
   input  logic [DataWidth-1:0] hw_ds_i,
   input  logic [DataWidth-1:0] hw_qs_i,
   output logic                 sub_req_o,
   output logic                 ack_o,
   output logic                 upd_o,
   output logic [DataWidth-1:0] qs_o
);

   if (HwUpd == 1'b0) begin : g_pass
      logic                  tgl_q, tgl_d;
      logic [SyncStages-1:0] sync_q, sync_d;
      logic                  dly_q, dly_d;
      logic                  unused_hw;

      always_comb begin
         tgl_d     = tgl_q ^ sw_req_i;
         sync_d    = sync_q;
         sync_d[0] = tgl_q;
         for (int unsigned i = 1; i < SyncStages; i++) begin
            sync_d[i] = sync_q[i-1];
         end
         dly_d = sync_q[SyncStages-1];
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            tgl_q  <= 1'b0;
            sync_q <= '0;
            dly_q  <= 1'b0;
         end else begin
            tgl_q  <= tgl_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
         end
      end

      assign sub_req_o = sw_req_i;
      assign ack_o     = sync_q[SyncStages-1] ^ dly_q;
      assign upd_o     = 1'b0;
      assign qs_o      = hw_qs_i;
      assign unused_hw = hw_update_i ^ (^hw_ds_i);

   end else begin : g_arb
      typedef enum logic {Idle, Wait} state_e;
      typedef enum logic {IdHw, IdSw} id_e;

      state_e                state_q, state_d;
      id_e                   id_q, id_d;
      logic                  pend_q, pend_d;
      logic [DataWidth-1:0]  qs_q, qs_d;
      logic                  tgl_q, tgl_d;
      logic [SyncStages-1:0] fwd_q, fwd_d;
      logic [SyncStages-1:0] ret_q, ret_d;
      logic                  fwd_dly_q, ret_dly_q;

      logic busy, req, acc_sw, acc_hw_d, acc_hw_q, accept;
      logic fwd_pulse, ret_pulse;

      assign busy      = (state_q == Wait);
      assign req       = sw_req_i | pend_q;
      assign acc_sw    = !busy & req;
      assign acc_hw_d  = !busy & !req & hw_update_i;
      assign acc_hw_q  = !busy & !req & !hw_update_i & (qs_q != hw_qs_i);
      assign accept    = acc_sw | acc_hw_d | acc_hw_q;
      assign fwd_pulse = fwd_q[SyncStages-1] ^ fwd_dly_q;
      assign ret_pulse = ret_q[SyncStages-1] ^ ret_dly_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            state_q   <= Idle;
            id_q      <= IdHw;
            pend_q    <= 1'b0;
            qs_q      <= ResetVal;
            tgl_q     <= 1'b0;
            fwd_q     <= '0;
            ret_q     <= '0;
            fwd_dly_q <= 1'b0;
            ret_dly_q <= 1'b0;
         end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            pend_q    <= pend_d;
            qs_q      <= qs_d;
            tgl_q     <= tgl_d;
            fwd_q     <= fwd_d;
            ret_q     <= ret_d;
            fwd_dly_q <= fwd_q[SyncStages-1];
            ret_dly_q <= ret_q[SyncStages-1];
         end
      end

      // Return path is fed from the forward level directly: the remote side acks immediately.
      always_comb begin
         state_d = state_q;
         case (state_q)
            Idle:    if (accept)    state_d = Wait;
            Wait:    if (ret_pulse) state_d = Idle;
            default: state_d = Idle;
         endcase

         qs_d = qs_q;
         if (acc_sw || acc_hw_d) qs_d = hw_ds_i;
         else if (acc_hw_q)      qs_d = hw_qs_i;

         pend_d = pend_q;
         if (acc_sw)                pend_d = 1'b0;
         else if (busy && sw_req_i) pend_d = 1'b1;

         id_d = id_q;
         if (accept) id_d = acc_sw ? IdSw : IdHw;

         tgl_d    = tgl_q ^ accept;
         fwd_d    = fwd_q;
         ret_d    = ret_q;
         fwd_d[0] = tgl_q;
         ret_d[0] = fwd_q[SyncStages-1];
         for (int unsigned i = 1; i < SyncStages; i++) begin
            fwd_d[i] = fwd_q[i-1];
            ret_d[i] = ret_q[i-1];
         end
      end

      always_comb begin
         sub_req_o = acc_sw;
         ack_o     = fwd_pulse & (id_q == IdSw);
         upd_o     = fwd_pulse & (id_q == IdHw);
         qs_o      = qs_q;
      end

`ifdef REG_UPD_HANDSHAKE_ASSERT_EN
      a_hw_id: assert property (@(posedge clk_i) disable iff (rst_i)
         (!busy && !req && hw_update_i) |=> (id_q == IdHw));
      a_hw_upd: assert property (@(posedge clk_i) disable iff (rst_i)
         (accept && !acc_sw) |-> ##[1:2*SyncStages+2] upd_o);
`else
`endif
   end

`ifdef REG_UPD_HANDSHAKE_ASSERT_EN
   a_excl: assert property (@(posedge clk_i) disable iff (rst_i) !(ack_o && upd_o));
`else
`endif

endmodule

// File: tb/tb_reg_upd_handshake.sv
// Directed bench: one passthrough and one arbitrated instance, SyncStages=2, DataWidth=8.
module tb_reg_upd_handshake;
   logic       clk = 1'b0;
   logic       rst;
   logic       pt_sw, ar_sw, hw_upd;
   logic [7:0] hw_ds, hw_qs;
   logic       pt_sub, pt_ack, pt_upd;
   logic       ar_sub, ar_ack, ar_upd;
   logic [7:0] pt_qs, ar_qs;
   int         checks   = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   reg_upd_handshake #(.DataWidth(8), .ResetVal(8'h3C), .HwUpd(1'b0), .SyncStages(2)) u_pt (
      .clk_i(clk), .rst_i(rst), .sw_req_i(pt_sw), .hw_update_i(hw_upd),
      .hw_ds_i(hw_ds), .hw_qs_i(hw_qs), .sub_req_o(pt_sub), .ack_o(pt_ack),
      .upd_o(pt_upd), .qs_o(pt_qs)
   );

   reg_upd_handshake #(.DataWidth(8), .ResetVal(8'h3C), .HwUpd(1'b1), .SyncStages(2)) u_ar (
      .clk_i(clk), .rst_i(rst), .sw_req_i(ar_sw), .hw_update_i(hw_upd),
      .hw_ds_i(hw_ds), .hw_qs_i(hw_qs), .sub_req_o(ar_sub), .ack_o(ar_ack),
      .upd_o(ar_upd), .qs_o(ar_qs)
   );

   task automatic chk(input string tag, input int cyc, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; pt_sw = 1'b0; ar_sw = 1'b0; hw_upd = 1'b0;
      hw_ds = 8'h00; hw_qs = 8'h3C;
      #12;
      chk("rst_pt_ack", 0, 8'(pt_ack), 8'h00);
      chk("rst_pt_upd", 0, 8'(pt_upd), 8'h00);
      chk("rst_ar_qs",  0, ar_qs,      8'h3C);
      chk("rst_ar_ack", 0, 8'(ar_ack), 8'h00);
      chk("rst_ar_upd", 0, 8'(ar_upd), 8'h00);
      chk("rst_ar_sub", 0, 8'(ar_sub), 8'h00);
      next_cycle();
      rst = 1'b0;
      next_cycle();

      // passthrough, single pulse
      for (int c = 0; c <= 6; c++) begin
         pt_sw = (c == 0);
         #3;
         chk("pt1_sub", c, 8'(pt_sub), 8'(c == 0));
         chk("pt1_ack", c, 8'(pt_ack), 8'(c == 3));
         chk("pt1_upd", c, 8'(pt_upd), 8'h00);
         next_cycle();
      end
      chk("pt_qs", 0, pt_qs, 8'h3C);

      // passthrough, back-to-back pulses
      for (int c = 0; c <= 7; c++) begin
         pt_sw = (c <= 1);
         #3;
         chk("pt2_ack", c, 8'(pt_ack), 8'((c == 3) || (c == 4)));
         next_cycle();
      end

      // arbitrated software write, second request while busy
      for (int c = 0; c <= 12; c++) begin
         ar_sw = (c == 0) || (c == 2);
         hw_ds = 8'h5A;
         hw_qs = (c >= 1) ? 8'h5A : 8'h3C;
         #3;
         chk("sw_sub", c, 8'(ar_sub), 8'((c == 0) || (c == 6)));
         chk("sw_ack", c, 8'(ar_ack), 8'((c == 3) || (c == 9)));
         chk("sw_upd", c, 8'(ar_upd), 8'h00);
         chk("sw_qs",  c, ar_qs, (c == 0) ? 8'h3C : 8'h5A);
         next_cycle();
      end

      // arbitrated hardware update, then mismatch left behind triggers latch Q
      for (int c = 0; c <= 12; c++) begin
         hw_upd = (c == 0);
         hw_ds  = 8'h11;
         hw_qs  = (c >= 2) ? 8'h22 : 8'h5A;
         #3;
         chk("hw_upd", c, 8'(ar_upd), 8'((c == 3) || (c == 9)));
         chk("hw_ack", c, 8'(ar_ack), 8'h00);
         chk("hw_sub", c, 8'(ar_sub), 8'h00);
         chk("hw_qs",  c, ar_qs, (c == 0) ? 8'h5A : ((c <= 6) ? 8'h11 : 8'h22));
         next_cycle();
      end

      // reset in cycle 2 of a software transaction with a pending request
      for (int c = 0; c <= 12; c++) begin
         ar_sw = (c <= 1);
         hw_ds = 8'h77;
         hw_qs = (c >= 2) ? 8'h3C : 8'h77;
         rst   = (c == 2) || (c == 3);
         #3;
         chk("rs_sub", c, 8'(ar_sub), 8'(c == 0));
         chk("rs_ack", c, 8'(ar_ack), 8'h00);
         chk("rs_upd", c, 8'(ar_upd), 8'h00);
         chk("rs_qs",  c, ar_qs, (c == 0) ? 8'h22 : ((c == 1) ? 8'h77 : 8'h3C));
         next_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
